// File: rtl/radix2_bf_pipe_pkg.sv
// Shared FFT datapath constants and fixed-point helpers: twiddle unity,
// round-half-up bias and signed saturation. Helpers work on a 64-bit container.
package radix2_bf_pipe_pkg;

    localparam int TW_W_DEF = 8;
    localparam int TW_ONE   = 1 << (TW_W_DEF - 2);

    typedef logic signed [63:0] wide_t;

    // Valid/mode side-band that travels alongside each butterfly
    typedef struct packed {
        logic vld;
        logic modify;
        logic scale;
    } side_t;

    // Bias that turns an arithmetic right shift by `shift` into round-half-up
    function automatic wide_t round_bias(input int shift);
        if (shift <= 0) return '0;
        return wide_t'(1) <<< (shift - 1);
    endfunction

    function automatic wide_t sat_to_width(input wide_t x, input int w);
        wide_t hi;
        wide_t lo;
        hi = (wide_t'(1) <<< (w - 1)) - wide_t'(1);
        lo = -(wide_t'(1) <<< (w - 1));
        if (x > hi) return hi;
        if (x < lo) return lo;
        return x;
    endfunction

endpackage

// File: rtl/radix2_bf_pipe_if.sv
// Butterfly pair bus: twiddles, modes and operands in; results and sticky ovf out.
// master drives the operands, slave is the butterfly datapath.
interface radix2_bf_pipe_if #(
    parameter int DATA_W = 16,
    parameter int TW_W   = 8
);
    logic                     in_valid;
    logic                     en_modify;
    logic                     scale;
    logic                     clr_ovf;
    logic signed [TW_W-1:0]   cos1;
    logic signed [TW_W-1:0]   sin1;
    logic signed [TW_W-1:0]   cos2;
    logic signed [TW_W-1:0]   sin2;
    logic signed [DATA_W-1:0] re_a;
    logic signed [DATA_W-1:0] im_a;
    logic signed [DATA_W-1:0] re_b;
    logic signed [DATA_W-1:0] im_b;
    logic                     out_valid;
    logic signed [DATA_W-1:0] re_o1;
    logic signed [DATA_W-1:0] im_o1;
    logic signed [DATA_W-1:0] re_o2;
    logic signed [DATA_W-1:0] im_o2;
    logic                     ovf;

    modport master (
        output in_valid, en_modify, scale, clr_ovf,
        output cos1, sin1, cos2, sin2, re_a, im_a, re_b, im_b,
        input  out_valid, re_o1, im_o1, re_o2, im_o2, ovf
    );

    modport slave (
        input  in_valid, en_modify, scale, clr_ovf,
        input  cos1, sin1, cos2, sin2, re_a, im_a, re_b, im_b,
        output out_valid, re_o1, im_o1, re_o2, im_o2, ovf
    );
endinterface

// File: rtl/radix2_bf_pipe_cmplx_rot_reg.sv
// Registered complex rotation y = x*w, rounded half up and saturated to DATA_W.
// Latency: 1 cycle. Backpressure: none; bypass registers x unchanged with no ovf.
// ovf is raised only for a valid, non-bypassed slot that hit saturation.
module cmplx_rot_reg
    import radix2_bf_pipe_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int TW_W   = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_vld,
    input  logic                     bypass,
    input  logic signed [DATA_W-1:0] xr,
    input  logic signed [DATA_W-1:0] xi,
    input  logic signed [TW_W-1:0]   c,
    input  logic signed [TW_W-1:0]   s,
    output logic signed [DATA_W-1:0] yr,
    output logic signed [DATA_W-1:0] yi,
    output logic                     ovf
);
    localparam int PW = DATA_W + TW_W;
    localparam int SW = PW + 1;
    localparam int SH = TW_W - 2;

    logic signed [PW-1:0] xr_c, xi_s, xi_c, xr_s;
    logic signed [SW-1:0] sum_re, sum_im;
    wide_t                rnd_re, rnd_im, sat_re, sat_im;
    logic                 sat_evt;

    assign xr_c   = PW'(xr) * PW'(c);
    assign xi_s   = PW'(xi) * PW'(s);
    assign xi_c   = PW'(xi) * PW'(c);
    assign xr_s   = PW'(xr) * PW'(s);
    assign sum_re = SW'(xr_c) - SW'(xi_s);
    assign sum_im = SW'(xi_c) + SW'(xr_s);

    assign rnd_re  = (64'(sum_re) + round_bias(SH)) >>> SH;
    assign rnd_im  = (64'(sum_im) + round_bias(SH)) >>> SH;
    assign sat_re  = sat_to_width(rnd_re, DATA_W);
    assign sat_im  = sat_to_width(rnd_im, DATA_W);
    assign sat_evt = (sat_re != rnd_re) || (sat_im != rnd_im);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            yr  <= '0;
            yi  <= '0;
            ovf <= 1'b0;
        end else if (bypass) begin
            yr  <= xr;
            yi  <= xi;
            ovf <= 1'b0;
        end else begin
            yr  <= sat_re[DATA_W-1:0];
            yi  <= sat_im[DATA_W-1:0];
            ovf <= in_vld & sat_evt;
        end
    end
endmodule

// File: rtl/radix2_bf_pipe.sv
// Pipelined radix-2 butterfly with optional second twiddle rotation on the lower output.
// Latency: 4 cycles (input reg, rot w1, rot w2/pass, add-scale-sat), one pair per cycle.
// Backpressure: none; bubbles propagate as out_valid=0 and outputs hold their last result.
module radix2_bf_pipe
    import radix2_bf_pipe_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int TW_W   = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    radix2_bf_pipe_if.slave    bus
);
    localparam int SUM_W = DATA_W + 1;

    side_t                    s1_side, s2_side, s3_side;
    logic signed [DATA_W-1:0] s1_ar, s1_ai, s1_br, s1_bi;
    logic signed [TW_W-1:0]   s1_w1c, s1_w1s, s1_w2c, s1_w2s;
    logic signed [DATA_W-1:0] s2_ar, s2_ai;
    logic signed [TW_W-1:0]   s2_w2c, s2_w2s;
    logic signed [DATA_W-1:0] s3_ar, s3_ai, s3_pr, s3_pi;
    logic                     s3_rot1_ovf;
    logic signed [DATA_W-1:0] p_re, p_im, q_re, q_im;
    logic                     p_ovf, q_ovf;
    logic [DATA_W:0]          f1r, f1i, f2r, f2i;
    logic                     sat_evt;

    // MSB of the result flags a saturation; the scaled path always fits
    function automatic logic [DATA_W:0] finish_sum(input logic signed [SUM_W-1:0] x,
                                                   input logic sc);
        wide_t w;
        wide_t r;
        w = 64'(x);
        if (sc) begin
            r = (w + round_bias(1)) >>> 1;
            return {1'b0, r[DATA_W-1:0]};
        end
        r = sat_to_width(w, DATA_W);
        return {(r != w), r[DATA_W-1:0]};
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_side <= '0;
            s1_ar   <= '0;
            s1_ai   <= '0;
            s1_br   <= '0;
            s1_bi   <= '0;
            s1_w1c  <= '0;
            s1_w1s  <= '0;
            s1_w2c  <= '0;
            s1_w2s  <= '0;
            s2_side <= '0;
            s2_ar   <= '0;
            s2_ai   <= '0;
            s2_w2c  <= '0;
            s2_w2s  <= '0;
            s3_side <= '0;
            s3_ar   <= '0;
            s3_ai   <= '0;
            s3_pr   <= '0;
            s3_pi   <= '0;
            s3_rot1_ovf <= 1'b0;
        end else begin
            s1_side <= '{vld: bus.in_valid, modify: bus.en_modify, scale: bus.scale};
            s1_ar   <= bus.re_a;
            s1_ai   <= bus.im_a;
            s1_br   <= bus.re_b;
            s1_bi   <= bus.im_b;
            s1_w1c  <= bus.cos1;
            s1_w1s  <= bus.sin1;
            s1_w2c  <= bus.cos2;
            s1_w2s  <= bus.sin2;
            s2_side <= s1_side;
            s2_ar   <= s1_ar;
            s2_ai   <= s1_ai;
            s2_w2c  <= s1_w2c;
            s2_w2s  <= s1_w2s;
            s3_side <= s2_side;
            s3_ar   <= s2_ar;
            s3_ai   <= s2_ai;
            s3_pr   <= p_re;
            s3_pi   <= p_im;
            s3_rot1_ovf <= p_ovf;
        end
    end

    cmplx_rot_reg #(.DATA_W(DATA_W), .TW_W(TW_W)) u_rot_w1 (
        .clk    (clk),
        .rst_n  (rst_n),
        .in_vld (s1_side.vld),
        .bypass (1'b0),
        .xr     (s1_br),
        .xi     (s1_bi),
        .c      (s1_w1c),
        .s      (s1_w1s),
        .yr     (p_re),
        .yi     (p_im),
        .ovf    (p_ovf)
    );

    // Classic mode passes p through so both modes share one latency
    cmplx_rot_reg #(.DATA_W(DATA_W), .TW_W(TW_W)) u_rot_w2 (
        .clk    (clk),
        .rst_n  (rst_n),
        .in_vld (s2_side.vld),
        .bypass (~s2_side.modify),
        .xr     (p_re),
        .xi     (p_im),
        .c      (s2_w2c),
        .s      (s2_w2s),
        .yr     (q_re),
        .yi     (q_im),
        .ovf    (q_ovf)
    );

    always_comb begin
        f1r = finish_sum(SUM_W'(s3_ar) + SUM_W'(s3_pr), s3_side.scale);
        f1i = finish_sum(SUM_W'(s3_ai) + SUM_W'(s3_pi), s3_side.scale);
        if (s3_side.modify) begin
            f2r = finish_sum(SUM_W'(s3_ar) + SUM_W'(q_re), s3_side.scale);
            f2i = finish_sum(SUM_W'(s3_ai) + SUM_W'(q_im), s3_side.scale);
        end else begin
            f2r = finish_sum(SUM_W'(s3_ar) - SUM_W'(q_re), s3_side.scale);
            f2i = finish_sum(SUM_W'(s3_ai) - SUM_W'(q_im), s3_side.scale);
        end
    end

    assign sat_evt = s3_side.vld & (s3_rot1_ovf | q_ovf | f1r[DATA_W] | f1i[DATA_W] |
                                    f2r[DATA_W] | f2i[DATA_W]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.out_valid <= 1'b0;
            bus.re_o1     <= '0;
            bus.im_o1     <= '0;
            bus.re_o2     <= '0;
            bus.im_o2     <= '0;
            bus.ovf       <= 1'b0;
        end else begin
            bus.out_valid <= s3_side.vld;
            if (s3_side.vld) begin
                bus.re_o1 <= f1r[DATA_W-1:0];
                bus.im_o1 <= f1i[DATA_W-1:0];
                bus.re_o2 <= f2r[DATA_W-1:0];
                bus.im_o2 <= f2i[DATA_W-1:0];
            end
            // A new saturation event beats a simultaneous clear
            if (sat_evt)
                bus.ovf <= 1'b1;
            else if (bus.clr_ovf)
                bus.ovf <= 1'b0;
        end
    end
endmodule

// File: tb/tb_radix2_bf_pipe.sv
// Directed-vector and streaming bench for radix2_bf_pipe at DATA_W=16, TW_W=8.
module tb_radix2_bf_pipe;
    import radix2_bf_pipe_pkg::*;

    localparam int DW = 16;
    localparam int TW = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    radix2_bf_pipe_if #(.DATA_W(DW), .TW_W(TW)) bus ();

    radix2_bf_pipe #(.DATA_W(DW), .TW_W(TW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int ar, ai, br, bi, c1, s1, c2, s2;
        bit md, sc;
    } pin_t;

    typedef struct {
        string name;
        pin_t  p;
        int    o1r, o1i, o2r, o2i;
        bit    ovf;
    } vec_t;

    typedef struct {
        bit     v;
        longint o1r, o1i, o2r, o2i;
        bit     ev;
    } exp_t;

    int checks   = 0;
    int failures = 0;
    vec_t vt[13];

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    function automatic pin_t mkp(input int ar, ai, br, bi, c1, s1, c2, s2, input bit md, sc);
        pin_t p;
        p.ar = ar; p.ai = ai; p.br = br; p.bi = bi;
        p.c1 = c1; p.s1 = s1; p.c2 = c2; p.s2 = s2;
        p.md = md; p.sc = sc;
        return p;
    endfunction

    function automatic vec_t mkv(input string n, input pin_t p,
                                 input int o1r, o1i, o2r, o2i, input bit ov);
        vec_t v;
        v.name = n; v.p = p;
        v.o1r = o1r; v.o1i = o1i; v.o2r = o2r; v.o2i = o2i; v.ovf = ov;
        return v;
    endfunction

    task automatic drive(input pin_t p, input bit v);
        bus.in_valid  = v;
        bus.en_modify = p.md;
        bus.scale     = p.sc;
        bus.re_a = DW'(p.ar);
        bus.im_a = DW'(p.ai);
        bus.re_b = DW'(p.br);
        bus.im_b = DW'(p.bi);
        bus.cos1 = TW'(p.c1);
        bus.sin1 = TW'(p.s1);
        bus.cos2 = TW'(p.c2);
        bus.sin2 = TW'(p.s2);
    endtask

    // Golden model, straight from the arithmetic definition
    function automatic longint sat_w(input longint x);
        longint hi, lo;
        hi = (longint'(1) <<< (DW - 1)) - 1;
        lo = -(longint'(1) <<< (DW - 1));
        return (x > hi) ? hi : ((x < lo) ? lo : x);
    endfunction

    function automatic longint rot_part(input longint x, output bit e);
        longint y, s;
        y = (x + (longint'(1) <<< (TW - 3))) >>> (TW - 2);
        s = sat_w(y);
        e = (s != y);
        return s;
    endfunction

    function automatic longint fin(input longint t, input bit sc, output bit e);
        longint s;
        if (sc) begin
            e = 1'b0;
            return (t + 1) >>> 1;
        end
        s = sat_w(t);
        e = (s != t);
        return s;
    endfunction

    function automatic exp_t model(input pin_t p);
        exp_t r;
        bit e;
        longint pr, pi, qr, qi;
        r.v = 1'b1; r.ev = 1'b0;
        pr = rot_part(longint'(p.br) * p.c1 - longint'(p.bi) * p.s1, e); r.ev |= e;
        pi = rot_part(longint'(p.bi) * p.c1 + longint'(p.br) * p.s1, e); r.ev |= e;
        r.o1r = fin(p.ar + pr, p.sc, e); r.ev |= e;
        r.o1i = fin(p.ai + pi, p.sc, e); r.ev |= e;
        if (p.md) begin
            qr = rot_part(pr * p.c2 - pi * p.s2, e); r.ev |= e;
            qi = rot_part(pi * p.c2 + pr * p.s2, e); r.ev |= e;
            r.o2r = fin(p.ar + qr, p.sc, e); r.ev |= e;
            r.o2i = fin(p.ai + qi, p.sc, e); r.ev |= e;
        end else begin
            r.o2r = fin(p.ar - pr, p.sc, e); r.ev |= e;
            r.o2i = fin(p.ai - pi, p.sc, e); r.ev |= e;
        end
        return r;
    endfunction

    function automatic int rnd_s(input int lim);
        return int'($urandom_range(0, 2 * lim)) - lim;
    endfunction

    task automatic pulse_clr();
        @(negedge clk); bus.clr_ovf = 1'b1;
        @(negedge clk); bus.clr_ovf = 1'b0;
    endtask

    task automatic apply_vec(input vec_t v);
        int lat;
        lat = 0;
        drive(v.p, 1'b1);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (k == 1) bus.in_valid = 1'b0;
            if (bus.out_valid) begin
                lat = k;
                break;
            end
        end
        chk({v.name, " latency"}, lat, 4);
        chk({v.name, " re_o1"}, $signed(bus.re_o1), v.o1r);
        chk({v.name, " im_o1"}, $signed(bus.im_o1), v.o1i);
        chk({v.name, " re_o2"}, $signed(bus.re_o2), v.o2r);
        chk({v.name, " im_o2"}, $signed(bus.im_o2), v.o2i);
        chk({v.name, " ovf"}, bus.ovf, v.ovf);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        exp_t   pipe[$];
        exp_t   e, blank;
        pin_t   p;
        bit     exp_ovf, prev_clr, prev_bubble, stale;
        int     sent, tail;

        vt[0]  = mkv("ident",    mkp(100, 0, 50, 0, TW_ONE, 0, 0, 0, 0, 0), 150, 0, 50, 0, 0);
        vt[1]  = mkv("j_tw",     mkp(100, 0, 50, 0, 0, TW_ONE, 0, 0, 0, 0), 100, 50, 100, -50, 0);
        vt[2]  = mkv("j_j_mod",  mkp(100, 0, 50, 0, 0, 64, 0, 64, 1, 0), 100, 50, 50, 0, 0);
        vt[3]  = mkv("rnd_pos",  mkp(0, 0, 3, 0, 32, 0, 0, 0, 0, 0), 2, 0, -2, 0, 0);
        vt[4]  = mkv("rnd_neg",  mkp(0, 0, -3, 0, 32, 0, 0, 0, 0, 0), -1, 0, 1, 0, 0);
        vt[5]  = mkv("scale_p",  mkp(101, 0, 0, 0, 64, 0, 0, 0, 0, 1), 51, 0, 51, 0, 0);
        vt[6]  = mkv("scale_n",  mkp(-101, 0, 0, 0, 64, 0, 0, 0, 0, 1), -50, 0, -50, 0, 0);
        vt[7]  = mkv("sat_pos",  mkp(32767, 0, 32767, 0, 64, 0, 0, 0, 0, 0), 32767, 0, 0, 0, 1);
        vt[8]  = mkv("sat_scl",  mkp(32767, 0, 32767, 0, 64, 0, 0, 0, 0, 1), 32767, 0, 0, 0, 0);
        vt[9]  = mkv("sat_neg",  mkp(-32768, 0, -32768, 0, 64, 0, 0, 0, 0, 0), -32768, 0, 0, 0, 1);
        vt[10] = mkv("rot1_sat", mkp(0, 0, -32768, 0, -128, 0, 0, 0, 0, 0), 32767, 0, -32767, 0, 1);
        vt[11] = mkv("cmplx",    mkp(10, 20, 30, 40, 45, 45, 0, 0, 0, 0), 3, 69, 17, -29, 0);
        vt[12] = mkv("rot2_sat", mkp(0, 0, 32767, 0, 64, 0, -128, 0, 1, 0), 32767, 0, -32768, 0, 1);

        bus.clr_ovf = 1'b0;
        drive(mkp(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1'b0);
        repeat (3) @(negedge clk);
        chk("reset out_valid", bus.out_valid, 0);
        chk("reset re_o1", $signed(bus.re_o1), 0);
        chk("reset im_o2", $signed(bus.im_o2), 0);
        chk("reset ovf", bus.ovf, 0);
        rst_n = 1'b1;

        foreach (vt[i]) begin
            pulse_clr();
            apply_vec(vt[i]);
            repeat (2) @(negedge clk);
            chk({vt[i].name, " hold vld"}, bus.out_valid, 0);
            chk({vt[i].name, " hold re_o2"}, $signed(bus.re_o2), vt[i].o2r);
        end

        // Sticky flag, explicit clear, and set beating a same-cycle clear
        pulse_clr();
        apply_vec(vt[7]);
        repeat (3) @(negedge clk);
        chk("ovf sticky", bus.ovf, 1);
        pulse_clr();
        chk("ovf cleared", bus.ovf, 0);
        drive(vt[7].p, 1'b1);
        @(negedge clk); bus.in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk); bus.clr_ovf = 1'b1;
        @(negedge clk); bus.clr_ovf = 1'b0;
        chk("ovf set wins", bus.ovf, 1);

        // Streaming with random modes, single bubbles and occasional clears
        pulse_clr();
        blank.v = 1'b0; blank.ev = 1'b0;
        blank.o1r = 0; blank.o1i = 0; blank.o2r = 0; blank.o2i = 0;
        repeat (4) pipe.push_back(blank);
        exp_ovf = 1'b0; prev_clr = 1'b0; prev_bubble = 1'b1;
        sent = 0; tail = 0;
        for (int cyc = 0; cyc < 400 && tail < 5; cyc++) begin
            @(negedge clk);
            e = pipe.pop_front();
            chk("stream out_valid", bus.out_valid, e.v);
            if (e.v) begin
                chk("stream re_o1", $signed(bus.re_o1), e.o1r);
                chk("stream im_o1", $signed(bus.im_o1), e.o1i);
                chk("stream re_o2", $signed(bus.re_o2), e.o2r);
                chk("stream im_o2", $signed(bus.im_o2), e.o2i);
            end
            exp_ovf = (e.v && e.ev) ? 1'b1 : (prev_clr ? 1'b0 : exp_ovf);
            chk("stream ovf", bus.ovf, exp_ovf);

            bus.clr_ovf = (sent < 64) && ($urandom_range(0, 9) == 0);
            prev_clr = bus.clr_ovf;
            if (sent < 64 && (prev_bubble || $urandom_range(0, 4) != 0)) begin
                p = mkp(rnd_s(20000), rnd_s(20000), rnd_s(20000), rnd_s(20000),
                        rnd_s(100), rnd_s(100), rnd_s(100), rnd_s(100),
                        1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
                drive(p, 1'b1);
                pipe.push_back(model(p));
                sent++;
                prev_bubble = 1'b0;
            end else begin
                // Bubble carries data that would saturate if it were counted
                drive(mkp(32767, 32767, -32768, 32767, -128, -128, -128, 127,
                          1'($urandom_range(0, 1)), 1'b0), 1'b0);
                pipe.push_back(blank);
                prev_bubble = 1'b1;
            end
            if (sent == 64) tail++;
        end
        chk("stream all sent", sent, 64);

        // Asynchronous reset with three pairs in flight
        pulse_clr();
        apply_vec(vt[7]);
        drive(vt[9].p, 1'b1);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk); bus.in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("midrst out_valid", bus.out_valid, 0);
        chk("midrst re_o1", $signed(bus.re_o1), 0);
        chk("midrst im_o1", $signed(bus.im_o1), 0);
        chk("midrst re_o2", $signed(bus.re_o2), 0);
        chk("midrst ovf", bus.ovf, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        stale = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (bus.out_valid || bus.ovf) stale = 1'b1;
        end
        chk("midrst no stale pair", stale, 0);
        apply_vec(vt[11]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/radix2_bf_pipe.md
# radix2_bf_pipe

Fully pipelined, parametrised radix-2 butterfly for the FFT datapath, with an optional second twiddle rotation ("modify" mode) on the lower output. It rounds and saturates every product and sum, can scale outputs by 1/2, and records overflow in a sticky flag. It takes one butterfly per clock at full throughput, has a fixed latency, and sits between the stage memory read port and the write-back path.

## Interface
- `DATA_W`, default 16: signed sample width, real and imaginary each.
- `TW_W`, default 8: signed twiddle width. Unity is 2^(TW_W-2), so 64 at the default.
- `clk` in 1: clock. Everything is on the rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `in_valid` in 1: input sample pair valid this cycle.
- `en_modify` in 1: mode for this pair. 0 = classic butterfly, 1 = double-rotated lower output.
- `scale` in 1: 1 = divide both outputs by 2 with rounding.
- `cos1`, `sin1` in TW_W: first twiddle w1 = cos1 + j·sin1.
- `cos2`, `sin2` in TW_W: second twiddle w2, used only when en_modify=1.
- `re_a`, `im_a` in DATA_W: upper input a.
- `re_b`, `im_b` in DATA_W: lower input b.
- `clr_ovf` in 1: synchronous clear of `ovf`.
- `out_valid` out 1: outputs valid.
- `re_o1`, `im_o1` out DATA_W: upper output.
- `re_o2`, `im_o2` out DATA_W: lower output.
- `ovf` out 1: sticky saturation flag.

## Operation
- `rot(x, w)` is a complex multiply:
  - Re = xr·c − xi·s; Im = xi·c + xr·s.
  - Full-precision products (DATA_W+TW_W bits) and sum (DATA_W+TW_W+1 bits).
  - Add 2^(TW_W-3) (round half up), then arithmetic right shift by TW_W-2.
  - Saturate to DATA_W.
- `p = rot(b, w1)`.
- `o1 = a + p`.
- `o2 = a − p` when en_modify=0; `o2 = a + rot(p, w2)` when en_modify=1.
- Sums are formed at DATA_W+1 bits.
  - scale=1: add 1, then arithmetic shift right by 1 (round half up). The result always fits.
  - scale=0: saturate to DATA_W.
- Saturation values: 2^(DATA_W-1)−1 and −2^(DATA_W-1).
- Any saturation event, in either rotation or either sum, on a valid pair sets `ovf` on the cycle that pair reaches the output.
- `ovf` holds until `clr_ovf`. If `clr_ovf` and a new event occur in the same cycle, set wins.
- `en_modify`, `scale` and all twiddles are captured with their pair and travel down the pipeline with it. Mode may change every cycle.
- When en_modify=0, the second rotation stage passes `p` through unchanged, so latency does not depend on mode.
- Bubbles (in_valid=0) propagate as out_valid=0. Data registers of invalid slots may hold any value, but must not affect `ovf`.

## Timing
- Pipeline stages:
  - S1: register inputs.
  - S2: rot w1.
  - S3: rot w2 or pass-through.
  - S4: add/sub, scale, saturate.
- Latency is exactly 4 cycles. A pair with in_valid high at edge n gives out_valid high after edge n+4.
- Throughput is 1 pair per cycle. There is no back-pressure.
- Reset values: `out_valid`=0, all data outputs 0, `ovf`=0, all internal valid bits 0.
- Reset mid-operation discards every in-flight pair. The first valid output after release comes 4 cycles after the first accepted input.
- Outputs are registered and held stable while out_valid=0, until the next valid result.

## Structure
- The shared FFT package holds:
  - the twiddle unity constant `TW_ONE = 1 << (TW_W-2)`;
  - the rounding-bias function;
  - the `sat_to_width` function.
- One sub-module, `cmplx_rot_reg`: one registered rounding and saturating complex rotation, with a bypass input and an ovf output. It is instantiated twice, for S2 and S3.
- The valid, mode and scale side-band is a small shift register inside the top level.

## Test plan
All values use DATA_W=16, TW_W=8.
1. **Identity twiddle.** a=(100,0), b=(50,0), w1=(64,0), modify=0, scale=0 → 4 cycles later o1=(150,0), o2=(50,0), ovf=0.
2. **j twiddle.** w1=(0,64), same a and b → o1=(100,50), o2=(100,−50). Then modify=1 with w2=(0,64) → o2=(50,0), since b·j·j = −50.
3. **Rounding.**
   - b=(3,0), w1=(32,0), a=0 → p=2 (1.5 rounds up), so o1=(2,0), o2=(−2,0).
   - scale=1 with a=(101,0), b=(0,0) → o1=(51,0).
4. **Saturation.**
   - a=(32767,0), b=(32767,0), w1=(64,0) → o1=(32767,0), o2=(0,0), ovf rises with that output and stays high.
   - clr_ovf → ovf=0 next cycle.
   - The same pair with scale=1 → o1=(32767,0) (65534/2 rounded) and no ovf.
5. **Streaming.** 64 back-to-back pairs with random modes, twiddles and scale, with single-cycle bubbles inserted → outputs match the golden model in order, and the out_valid pattern equals the in_valid pattern delayed by 4.
6. **Reset mid-stream.** Assert rst_n low asynchronously with 3 pairs in flight → out_valid=0, outputs 0 and ovf=0 immediately. No stale pair appears after release.
